// File: rtl/ok_pipe_out_blocker.sv
// ok_pipe_out_blocker
// Merges several producer channels into one FIFO and feeds a block-throttled pipe-out endpoint.
// Whole blocks of B = 2**Nblock words are offered; a partial block left idle for TIMEOUT
// cycles is flushed and padded out with NOP words.
//
// Ports:
//   okClk       - clock, rising edge
//   user_reset  - asynchronous active-high reset
//   up_v/up_d   - per-channel valid and data (channel i at [i*W +: W])
//   up_a        - per-channel ack, one-hot or zero, combinational
//   ep_ready    - registered block-ready to the endpoint
//   ep_read     - endpoint consumes one word this cycle
//   ep_datain   - word presented to the endpoint (show-ahead)
//   fifo_count  - FIFO occupancy
//   nop_count   - saturating count of padding words emitted
module ok_pipe_out_blocker #(
    parameter int NCHAN   = 2,
    parameter int NPCcode = 8,
    parameter int NPCdata = 24,
    parameter int NOPcode = 64,
    parameter int Nfifo   = 9,
    parameter int Nblock  = 7,
    parameter int TIMEOUT = 1024,
    localparam int W      = NPCcode + NPCdata
) (
    input  logic                 okClk,
    input  logic                 user_reset,
    input  logic [NCHAN-1:0]     up_v,
    input  logic [NCHAN*W-1:0]   up_d,
    output logic [NCHAN-1:0]     up_a,
    output logic                 ep_ready,
    input  logic                 ep_read,
    output logic [W-1:0]         ep_datain,
    output logic [Nfifo:0]       fifo_count,
    output logic [15:0]          nop_count
);

    localparam int DEPTH = 1 << Nfifo;
    localparam int PW    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [Nfifo:0] FULL_C   = (Nfifo+1)'(DEPTH);
    localparam logic [Nfifo:0] BLK_C    = (Nfifo+1)'(1 << Nblock);
    localparam logic [W-1:0]   NOP_WORD = {NPCcode'(NOPcode), NPCdata'(0)};

    typedef enum logic [1:0] {
        StIdle,
        StXferData,
        StXferPad
    } state_e;

    state_e              r_state, w_state_d;
    logic [W-1:0]        r_mem [DEPTH];
    logic [Nfifo-1:0]    r_wr_ptr, r_rd_ptr;
    logic [Nfifo:0]      r_count;
    logic [PW-1:0]       r_rr_ptr;
    logic                r_ep_ready, w_ready_d;
    logic                r_flush, w_flush_d;
    logic [TW-1:0]       r_timer, w_timer_d;
    logic [Nblock-1:0]   r_blk_cnt, w_blk_cnt_d;
    logic [15:0]         r_nop_cnt;

    logic                w_gnt_valid;
    logic [PW-1:0]       w_gnt_idx;
    logic [PW-1:0]       w_rr_next;
    logic [W-1:0]        w_push_data;
    logic                w_full, w_empty;
    logic                w_rd_accept, w_pad, w_pop, w_nop, w_push;

    // Round-robin search starting at r_rr_ptr, which holds (last granted + 1) mod NCHAN.
    always_comb begin
        int v_idx;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        v_idx       = 0;
        for (int k = 0; k < NCHAN; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NCHAN;
            if (!w_gnt_valid && up_v[v_idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = PW'(v_idx);
            end
        end
    end

    assign w_rr_next   = (w_gnt_idx == PW'(NCHAN - 1)) ? '0 : w_gnt_idx + PW'(1);
    assign w_push_data = up_d[w_gnt_idx*W +: W];

    assign w_full  = (r_count == FULL_C);
    assign w_empty = (r_count == '0);

    // A read in IDLE only counts once a block has been offered.
    assign w_rd_accept = ep_read && ((r_state != StIdle) || r_ep_ready);
    // Padding once in XFER_PAD, or when the flushed block has run dry.
    assign w_pad       = (r_state == StXferPad) || w_empty;
    assign w_pop       = w_rd_accept && !w_pad;
    assign w_nop       = w_rd_accept && w_pad;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign w_push      = w_gnt_valid && (!w_full || w_pop) && !user_reset;

    assign up_a       = w_push ? (NCHAN'(1) << w_gnt_idx) : '0;
    assign ep_datain  = w_pad ? NOP_WORD : r_mem[r_rd_ptr];
    assign ep_ready   = r_ep_ready;
    assign fifo_count = r_count;
    assign nop_count  = r_nop_cnt;

    // Block FSM, ready/flush/timer next-state.
    always_comb begin
        w_state_d   = r_state;
        w_blk_cnt_d = r_blk_cnt;
        w_ready_d   = r_ep_ready;
        w_flush_d   = r_flush;
        w_timer_d   = r_timer;
        unique case (r_state)
            StIdle: begin
                if (w_rd_accept) begin
                    // This read is word 0 of the block.
                    w_state_d   = w_empty ? StXferPad : StXferData;
                    w_blk_cnt_d = Nblock'(1);
                    w_timer_d   = '0;
                    w_ready_d   = 1'b1;
                end else begin
                    w_ready_d = (r_count >= BLK_C) || r_flush;
                    if (w_empty || (r_count >= BLK_C) || r_flush) begin
                        w_timer_d = '0;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        w_timer_d = '0;
                        w_flush_d = 1'b1;
                    end else begin
                        w_timer_d = r_timer + TW'(1);
                    end
                end
            end
            StXferData, StXferPad: begin
                w_timer_d = '0;
                if (w_rd_accept) begin
                    w_blk_cnt_d = r_blk_cnt + Nblock'(1);
                    if (w_pad) begin
                        w_state_d = StXferPad;
                    end
                    if (&r_blk_cnt) begin
                        // ep_ready stays up until the next IDLE evaluation.
                        w_state_d = StIdle;
                        w_flush_d = 1'b0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge okClk or posedge user_reset) begin
        if (user_reset) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rr_ptr   <= '0;
            r_ep_ready <= 1'b0;
            r_flush    <= 1'b0;
            r_timer    <= '0;
            r_blk_cnt  <= '0;
            r_nop_cnt  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_ep_ready <= w_ready_d;
            r_flush    <= w_flush_d;
            r_timer    <= w_timer_d;
            r_blk_cnt  <= w_blk_cnt_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + Nfifo'(1);
                r_rr_ptr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + Nfifo'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (Nfifo+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (Nfifo+1)'(1);
            end
            if (w_nop && (r_nop_cnt != 16'hFFFF)) begin
                r_nop_cnt <= r_nop_cnt + 16'd1;
            end
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge okClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

endmodule

// File: doc/ok_pipe_out_blocker.md
OK_PIPE_OUT_BLOCKER -- requirements
Module: ok_pipe_out_blocker

Interface
REQ-001 SHALL have parameter NCHAN, default 2: number of upstream producer channels (1..8).
REQ-002 SHALL have parameter NPCcode, default 8: width of the code field.
REQ-003 SHALL have parameter NPCdata, default 24: width of the payload field; word width W = NPCcode+NPCdata.
REQ-004 SHALL have parameter NOPcode, default 64: code placed in padding words.
REQ-005 SHALL have parameter Nfifo, default 9: log2 of FIFO depth (512 words).
REQ-006 SHALL have parameter Nblock, default 7: log2 of pipe block length B (128 words); Nblock < Nfifo.
REQ-007 SHALL have parameter TIMEOUT, default 1024: idle cycles (>=1) before a partial block is flushed.
REQ-008 SHALL have port okClk, input, 1: sole clock, rising edge.
REQ-009 SHALL have port user_reset, input, 1: reset, asynchronous, active-high.
REQ-010 SHALL have port up_v, input, NCHAN: per-channel valid.
REQ-011 SHALL have port up_d, input, NCHAN*W: per-channel data, channel i at [i*W +: W].
REQ-012 SHALL have port up_a, output, NCHAN: per-channel ack, one-hot or zero.
REQ-013 SHALL have port ep_ready, output, 1: block-ready to the block-throttled pipe-out endpoint.
REQ-014 SHALL have port ep_read, input, 1: endpoint consumes one word this cycle.
REQ-015 SHALL have port ep_datain, output, W: word presented to the endpoint.
REQ-016 SHALL have port fifo_count, output, Nfifo+1: current FIFO occupancy.
REQ-017 SHALL have port nop_count, output, 16: saturating count of padding words emitted.

Function
REQ-018 SHALL accept at most one channel per cycle: grant = first i with up_v[i]=1, searching round-robin from (last granted + 1) mod NCHAN.
REQ-019 SHALL assert up_a[i] combinationally in the cycle of grant, only when the FIFO is not full (or a pop occurs the same cycle); the word is written at that clock edge.
REQ-020 SHALL update the round-robin pointer only on an accepted word.
REQ-021 SHALL present FIFO head on ep_datain combinationally (show-ahead); when emitting padding, ep_datain = {NOPcode, NPCdata zeros}.
REQ-022 SHALL implement states IDLE, XFER_DATA, XFER_PAD; block word counter of Nblock bits.
REQ-023 IDLE: ep_ready (registered) = 1 when fifo_count >= B or flush_pending=1; first ep_read moves to XFER_DATA, clears the timeout timer, and counts as word 0.
REQ-024 XFER_DATA: each ep_read pops one word; if FIFO is empty at an ep_read (flush block only), emit NOP instead, no pop, and go to XFER_PAD.
REQ-025 XFER_PAD: each ep_read emits NOP without popping, even if FIFO has refilled.
REQ-026 SHALL return to IDLE after the B-th ep_read of a block, clear flush_pending, and drop ep_ready on the following edge if IDLE condition is false.
REQ-027 SHALL hold ep_ready stable for a whole block (it is only re-evaluated in IDLE).
REQ-028 Timeout timer counts in IDLE while 0 < fifo_count < B; resets to 0 when fifo_count = 0 or >= B; reaching TIMEOUT sets flush_pending.
REQ-029 Simultaneous push and pop SHALL leave fifo_count unchanged and be permitted when full.
REQ-030 ep_read in IDLE with ep_ready=0 SHALL be ignored (no pop, no state change).
REQ-031 nop_count SHALL increment per NOP emitted and saturate at 16'hFFFF.

Reset
REQ-032 On user_reset=1, asynchronously: state=IDLE, FIFO empty, fifo_count=0, ep_ready=0, up_a=0, rr pointer=0, timer=0, flush_pending=0, nop_count=0; a reset mid-block aborts the block and discards FIFO contents.

Verification (NCHAN=2, W=32, Nfifo=4, Nblock=2 (B=4), TIMEOUT=8, NOPcode=64)
REQ-033 Push 4 words on ch0 -> ep_ready=1 one cycle after 4th accept; 4 ep_reads return the words in order; ep_ready=0 afterward, nop_count=0.
REQ-034 up_v=2'b11 held for 4 cycles -> up_a sequence 01,10,01,10; FIFO order ch0,ch1,ch0,ch1.
REQ-035 Push 1 word 32'h0A000001, idle -> ep_ready=1 after 8 idle cycles; block reads 32'h0A000001, then 3x 32'h40000000; nop_count=3.
REQ-036 Fill FIFO to 16 with up_v=1 -> up_a=0; assert ep_read same cycle -> up_a=1, fifo_count stays 16.
REQ-037 Assert user_reset after 2 of 4 block reads -> ep_ready=0, fifo_count=0, state IDLE immediately; next 4-word push behaves as REQ-033.
